// File: rtl/reg_file_param.sv
// Parametrised register file: one byte-masked write port, two registered read ports with
// write-first forwarding, a sequenced clear sweep and an optional hardwired zero entry.
module reg_file_param #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 3,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [DATA_W-1:0]   i_wr_data,
   input  logic [DATA_W/8-1:0] i_wr_be,
   output logic                o_wr_accept,
   input  logic [ADDR_W-1:0]   i_rd0_addr,
   output logic [DATA_W-1:0]   o_rd0_data,
   input  logic [ADDR_W-1:0]   i_rd1_addr,
   output logic [DATA_W-1:0]   o_rd1_data,
   input  logic                i_clear,
   output logic                o_busy
);

   localparam int unsigned     DEPTH  = 1 << ADDR_W;
   localparam int unsigned     NBYTES = DATA_W / 8;
   localparam logic [ADDR_W:0] LAST   = (ADDR_W + 1)'(DEPTH - 1);

   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   state_e            r_state, w_state_nxt;
   logic [ADDR_W:0]   r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0] r_mem     [DEPTH];
   logic [DATA_W-1:0] w_mem_nxt [DEPTH];
   logic [DATA_W-1:0] w_wr_word;
   logic [DATA_W-1:0] r_rd0, r_rd1;
   logic              w_busy, w_accept;

   assign w_busy      = (r_state == StSweep);
   assign w_accept    = i_wr_en & ~w_busy;
   assign o_busy      = w_busy;
   assign o_wr_accept = w_accept;
   assign o_rd0_data  = r_rd0;
   assign o_rd1_data  = r_rd1;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (i_clear) begin
               w_state_nxt = StSweep;
               w_cnt_nxt   = '0;
            end
         end
         StSweep: begin
            w_cnt_nxt = r_cnt + (ADDR_W + 1)'(1);
            if (r_cnt == LAST) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_wr_word = r_mem[i_wr_addr];
      for (int unsigned k = 0; k < NBYTES; k++) begin
         if (i_wr_be[k]) w_wr_word[8*k +: 8] = i_wr_data[8*k +: 8];
      end
   end

   // Reads sample this array, so writes and sweep zeroing forward to the read ports.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         w_mem_nxt[i] = r_mem[i];
         if (w_accept && i_wr_addr == ADDR_W'(i)) w_mem_nxt[i] = w_wr_word;
         if (w_busy && r_cnt[ADDR_W-1:0] == ADDR_W'(i)) w_mem_nxt[i] = '0;
         if (ZERO_REG && i == 0) w_mem_nxt[i] = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_rd0   <= '0;
         r_rd1   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rd0   <= w_mem_nxt[i_rd0_addr];
         r_rd1   <= w_mem_nxt[i_rd1_addr];
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= w_mem_nxt[i];
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: 8-bit default instance, a 16-bit instance and a
// ZERO_REG instance driven from shared stimulus.
module tb_reg_file_param;

   logic        clk = 1'b0;
   logic        reset, wr_en, clear;
   logic [2:0]  wr_addr, rd0_addr, rd1_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;

   logic        a_acc, a_busy, b_acc, b_busy, z_acc, z_busy;
   logic [7:0]  a_rd0, a_rd1, z_rd0, z_rd1;
   logic [15:0] b_rd0, b_rd1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0)) u_a (
      .CLK(clk), .RESET(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data[7:0]), .i_wr_be(wr_be[0]), .o_wr_accept(a_acc),
      .i_rd0_addr(rd0_addr), .o_rd0_data(a_rd0), .i_rd1_addr(rd1_addr), .o_rd1_data(a_rd1),
      .i_clear(clear), .o_busy(a_busy)
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_b (
      .CLK(clk), .RESET(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data), .i_wr_be(wr_be), .o_wr_accept(b_acc),
      .i_rd0_addr(rd0_addr), .o_rd0_data(b_rd0), .i_rd1_addr(rd1_addr), .o_rd1_data(b_rd1),
      .i_clear(clear), .o_busy(b_busy)
   );

   reg_file_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1)) u_z (
      .CLK(clk), .RESET(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
      .i_wr_data(wr_data[7:0]), .i_wr_be(wr_be[0]), .o_wr_accept(z_acc),
      .i_rd0_addr(rd0_addr), .o_rd0_data(z_rd0), .i_rd1_addr(rd1_addr), .o_rd1_data(z_rd1),
      .i_clear(clear), .o_busy(z_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; wr_en = 1'b0; clear = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
      rd0_addr = '0; rd1_addr = '0;
      tick();
      reset = 1'b0;
   endtask

   // Entry i <- base + i on the 8-bit instances (low byte only).
   task automatic fill(input logic [7:0] base);
      wr_en = 1'b1; wr_be = 2'b01;
      for (int i = 0; i < 8; i++) begin
         wr_addr = 3'(i); wr_data = {8'h00, base + 8'(i)};
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nvec++;
      if (a_busy !== 1'b0) begin
         nerr++; $display("FAIL reset_busy got %b want 0", a_busy);
      end
      for (int i = 0; i < 8; i++) begin
         rd0_addr = 3'(i); rd1_addr = 3'(7 - i);
         tick();
         nvec++;
         if (a_rd0 !== 8'h00 || a_rd1 !== 8'h00 || b_rd0 !== 16'h0 || b_rd1 !== 16'h0) begin
            nerr++;
            $display("FAIL reset_read[%0d] got %h/%h/%h/%h want 0", i, a_rd0, a_rd1, b_rd0, b_rd1);
         end
      end
   endtask

   task automatic test_write();
      do_reset();
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00FF; wr_be = 2'b11;
      #1;
      nvec++;
      if (a_acc !== 1'b1 || b_acc !== 1'b1) begin
         nerr++; $display("FAIL write_accept got %b/%b want 1/1", a_acc, b_acc);
      end
      tick();
      wr_data = 16'h3C00; wr_be = 2'b10;   // 8-bit instances see BE=0: accepted no-op
      tick();
      wr_addr = 3'd5; wr_data = 16'h00A5; wr_be = 2'b01;
      tick();
      wr_en = 1'b0; rd0_addr = 3'd5; rd1_addr = 3'd2;
      tick();
      nvec++;
      if (a_rd0 !== 8'hA5) begin
         nerr++; $display("FAIL write_a5 got %h want a5", a_rd0);
      end
      nvec++;
      if (a_rd1 !== 8'hFF) begin
         nerr++; $display("FAIL write_be0_noop got %h want ff", a_rd1);
      end
      nvec++;
      if (b_rd1 !== 16'h3CFF) begin
         nerr++; $display("FAIL write_byte_merge got %h want 3cff", b_rd1);
      end
      nvec++;
      if (b_rd0 !== 16'h00A5) begin
         nerr++; $display("FAIL write_16_low got %h want 00a5", b_rd0);
      end
   endtask

   task automatic test_forward();
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h007E; wr_be = 2'b01;
      rd0_addr = 3'd3; rd1_addr = 3'd3;
      tick();
      wr_en = 1'b0;
      nvec++;
      if (a_rd0 !== 8'h7E || a_rd1 !== 8'h7E) begin
         nerr++; $display("FAIL forward_both got %h/%h want 7e/7e", a_rd0, a_rd1);
      end
      nvec++;
      if (b_rd0 !== 16'h007E) begin
         nerr++; $display("FAIL forward_16 got %h want 007e", b_rd0);
      end
   endtask

   task automatic test_sweep();
      int n;
      fill(8'h10);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n = 0;
      while (a_busy === 1'b1 && n < 20) begin
         if (n == 3) clear = 1'b1;            // must not restart the sweep
         if (n == 4) clear = 1'b0;
         if (n == 5) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0055; wr_be = 2'b01;
            #1;
            nvec++;
            if (a_acc !== 1'b0) begin
               nerr++; $display("FAIL sweep_wr_accept got %b want 0", a_acc);
            end
         end
         n++;
         tick();
         wr_en = 1'b0;
      end
      nvec++;
      if (n != 8) begin
         nerr++; $display("FAIL sweep_busy_cycles got %0d want 8", n);
      end
      for (int i = 0; i < 8; i++) begin
         rd0_addr = 3'(i);
         tick();
         nvec++;
         if (a_rd0 !== 8'h00) begin
            nerr++; $display("FAIL sweep_cleared[%0d] got %h want 00", i, a_rd0);
         end
      end
   endtask

   task automatic test_reset_in_sweep();
      fill(8'h40);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      rd0_addr = 3'd5; rd1_addr = 3'd1;
      for (int i = 0; i < 3; i++) tick();
      nvec++;
      if (a_rd0 !== 8'h45 || a_rd1 !== 8'h00) begin
         nerr++; $display("FAIL sweep_partial got %h/%h want 45/00", a_rd0, a_rd1);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nvec++;
      if (a_busy !== 1'b0 || a_rd0 !== 8'h00) begin
         nerr++; $display("FAIL reset_in_sweep got busy=%b rd0=%h want 0/00", a_busy, a_rd0);
      end
      for (int i = 4; i < 8; i++) begin
         rd0_addr = 3'(i);
         tick();
         nvec++;
         if (a_rd0 !== 8'h00) begin
            nerr++; $display("FAIL reset_in_sweep_rd[%0d] got %h want 00", i, a_rd0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      wr_en = 1'b1; clear = 1'b1; wr_addr = 3'd4; wr_data = 16'h0099; wr_be = 2'b01;
      #1;
      nvec++;
      if (a_acc !== 1'b1) begin
         nerr++; $display("FAIL clear_wr_accept got %b want 1", a_acc);
      end
      tick();
      wr_en = 1'b0; clear = 1'b0; rd0_addr = 3'd4;
      tick();
      nvec++;
      if (a_busy !== 1'b1 || a_rd0 !== 8'h99) begin
         nerr++; $display("FAIL clear_wr_unswept got busy=%b rd0=%h want 1/99", a_busy, a_rd0);
      end
      n = 0;
      while (a_busy === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      nvec++;
      if (a_rd0 !== 8'h00 || n >= 20) begin
         nerr++; $display("FAIL clear_wr_zeroed got %h after %0d want 00", a_rd0, n);
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h00FF; wr_be = 2'b01; rd0_addr = 3'd0;
      #1;
      nvec++;
      if (z_acc !== 1'b1) begin
         nerr++; $display("FAIL zero_reg_accept got %b want 1", z_acc);
      end
      tick();
      wr_en = 1'b0;
      nvec++;
      if (z_rd0 !== 8'h00 || a_rd0 !== 8'hFF) begin
         nerr++; $display("FAIL zero_reg_fwd got z=%h a=%h want 00/ff", z_rd0, a_rd0);
      end
      tick();
      nvec++;
      if (z_rd0 !== 8'h00) begin
         nerr++; $display("FAIL zero_reg_read got %h want 00", z_rd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_write();
      test_forward();
      test_sweep();
      test_reset_in_sweep();
      test_back_to_back();
      test_zero_reg();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
